// File: rtl/uart_apb_regfile_v2.sv
// UART APB3 register file, second generation.
// Bridges APB3 to TX/RX FIFOs, control registers and sticky IRQ status.
module uart_apb_regfile_v2 #(
    parameter int          APB_ADDR_WIDTH = 32,
    parameter int          FIFO_DW        = 8,
    parameter int          N_IRQ          = 8,
    parameter int          WAIT_TIMEOUT   = 16,
    parameter logic [15:0] BITLEN_RST     = 16'd1000,
    parameter logic [31:0] HWINFO_VAL     = 32'h0
) (
    input  logic                      i_apb_pclk,
    input  logic                      i_apb_presetn,
    input  logic [APB_ADDR_WIDTH-1:0] i_apb_paddr,
    input  logic [31:0]               i_apb_pwdata,
    input  logic                      i_apb_pwrite,
    input  logic                      i_apb_psel,
    input  logic                      i_apb_penable,
    output logic [31:0]               o_apb_prdata,
    output logic                      o_apb_pready,
    output logic                      o_apb_pslverr,
    input  logic [N_IRQ-1:0]          i_irq_events,
    output logic                      o_irq,
    input  logic [31:0]               i_stats,
    output logic                      o_dfifo_wr,
    output logic [FIFO_DW-1:0]        o_dfifo_data,
    input  logic                      i_dfifo_full,
    output logic                      o_ufifo_rd,
    input  logic [FIFO_DW-1:0]        i_ufifo_data,
    input  logic                      i_ufifo_empty,
    output logic [7:0]                o_ctrl,
    output logic [15:0]               o_bit_length
);

    localparam int CW = $clog2(WAIT_TIMEOUT + 1) + 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_RESP
    } state_e;

    state_e            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [7:0]        ctrl_q, ctrl_d;
    logic [15:0]       bitlen_q, bitlen_d;
    logic [N_IRQ-1:0]  irq_en_q, irq_en_d;
    logic [N_IRQ-1:0]  irq_sts_q, irq_sts_d;
    logic [N_IRQ-1:0]  sts_clr;
    logic              irq_q, irq_d;
    logic              pready_q, pready_d;
    logic              pslverr_q, pslverr_d;
    logic [31:0]       prdata_q, prdata_d;
    logic [31:0]       rdata;
    logic              dfifo_wr, ufifo_rd;
    logic [4:0]        off;
    logic              access, addr_err, ro_err, bad;
    logic              unused_ok;

    assign off       = i_apb_paddr[4:0];
    assign access    = i_apb_psel & i_apb_penable;
    assign addr_err  = (off[1:0] != 2'b00) || ((i_apb_paddr >> 5) != '0);
    assign ro_err    = i_apb_pwrite &&
                       (off == 5'h14 || off == 5'h18 || off == 5'h1C);
    assign bad       = addr_err | ro_err;
    assign unused_ok = ^i_apb_pwdata;

    always_comb begin
        rdata = '0;
        case (off)
            5'h00:   rdata = 32'(ctrl_q);
            5'h04:   rdata = 32'(bitlen_q);
            5'h08:   rdata = 32'(irq_en_q);
            5'h0C:   rdata = 32'(irq_sts_q);
            5'h14:   if (!i_ufifo_empty) rdata = 32'h8000_0000 | 32'(i_ufifo_data);
            5'h18:   rdata = i_stats;
            5'h1C:   rdata = HWINFO_VAL;
            default: rdata = '0;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        ctrl_d    = ctrl_q;
        bitlen_d  = bitlen_q;
        irq_en_d  = irq_en_q;
        pready_d  = 1'b0;
        pslverr_d = 1'b0;
        prdata_d  = '0;
        dfifo_wr  = 1'b0;
        ufifo_rd  = 1'b0;
        sts_clr   = '0;
        unique case (state_q)
            S_IDLE: begin
                if (access) begin
                    if (!bad && i_apb_pwrite && off == 5'h10 && i_dfifo_full) begin
                        state_d = S_WAIT;
                        cnt_d   = CW'(1);
                    end else begin
                        state_d  = S_RESP;
                        pready_d = 1'b1;
                        if (bad) begin
                            pslverr_d = 1'b1;
                        end else if (i_apb_pwrite) begin
                            case (off)
                                5'h00:   ctrl_d   = i_apb_pwdata[7:0];
                                5'h04:   bitlen_d = i_apb_pwdata[15:0];
                                5'h08:   irq_en_d = i_apb_pwdata[N_IRQ-1:0];
                                5'h0C:   sts_clr  = i_apb_pwdata[N_IRQ-1:0];
                                5'h10:   dfifo_wr = 1'b1;
                                default: ;
                            endcase
                        end else begin
                            prdata_d = rdata;
                            ufifo_rd = (off == 5'h14) && !i_ufifo_empty;
                        end
                    end
                end
            end
            S_WAIT: begin
                if (!i_dfifo_full) begin
                    dfifo_wr = 1'b1;
                    state_d  = S_RESP;
                    pready_d = 1'b1;
                end else if (cnt_q == CW'(WAIT_TIMEOUT)) begin
                    pslverr_d = 1'b1;
                    state_d   = S_RESP;
                    pready_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_RESP:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        // new events override a same-cycle W1C
        irq_sts_d = (irq_sts_q & ~sts_clr) | i_irq_events;
        irq_d     = |(irq_sts_q & irq_en_q);
    end

    always_ff @(posedge i_apb_pclk or negedge i_apb_presetn) begin
        if (!i_apb_presetn) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            ctrl_q    <= '0;
            bitlen_q  <= BITLEN_RST;
            irq_en_q  <= '0;
            irq_sts_q <= '0;
            irq_q     <= 1'b0;
            pready_q  <= 1'b0;
            pslverr_q <= 1'b0;
            prdata_q  <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            ctrl_q    <= ctrl_d;
            bitlen_q  <= bitlen_d;
            irq_en_q  <= irq_en_d;
            irq_sts_q <= irq_sts_d;
            irq_q     <= irq_d;
            pready_q  <= pready_d;
            pslverr_q <= pslverr_d;
            prdata_q  <= prdata_d;
        end
    end

    assign o_apb_prdata  = prdata_q;
    assign o_apb_pready  = pready_q;
    assign o_apb_pslverr = pslverr_q;
    assign o_irq         = irq_q;
    assign o_dfifo_wr    = dfifo_wr;
    assign o_dfifo_data  = i_apb_pwdata[FIFO_DW-1:0];
    assign o_ufifo_rd    = ufifo_rd;
    assign o_ctrl        = ctrl_q;
    assign o_bit_length  = bitlen_q;

endmodule

// File: tb/tb_uart_apb_regfile_v2.sv
// Bench for uart_apb_regfile_v2: directed scenarios plus randomized
// APB traffic checked against a register-level reference model.
module tb_uart_apb_regfile_v2;

    localparam int W = 16;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] paddr = '0;
    logic [31:0] pwdata = '0;
    logic        pwrite = 1'b0;
    logic        psel = 1'b0;
    logic        penable = 1'b0;
    logic [31:0] o_apb_prdata;
    logic        o_apb_pready;
    logic        o_apb_pslverr;
    logic [7:0]  irq_ev = '0;
    logic        o_irq;
    logic [31:0] stats = '0;
    logic        o_dfifo_wr;
    logic [7:0]  o_dfifo_data;
    logic        full = 1'b0;
    logic        o_ufifo_rd;
    logic [7:0]  udata = '0;
    logic        empty = 1'b1;
    logic [7:0]  o_ctrl;
    logic [15:0] o_bit_length;

    int n_cmp = 0;
    int n_bad = 0;

    logic [7:0]  m_ctrl;
    logic [15:0] m_bitlen;
    logic [7:0]  m_en;
    logic [7:0]  m_sts;

    always #5 clk = ~clk;

    uart_apb_regfile_v2 #(
        .APB_ADDR_WIDTH(32),
        .FIFO_DW(8),
        .N_IRQ(8),
        .WAIT_TIMEOUT(W),
        .BITLEN_RST(16'd1000),
        .HWINFO_VAL(32'h0)
    ) dut (
        .i_apb_pclk(clk),
        .i_apb_presetn(rst_n),
        .i_apb_paddr(paddr),
        .i_apb_pwdata(pwdata),
        .i_apb_pwrite(pwrite),
        .i_apb_psel(psel),
        .i_apb_penable(penable),
        .o_apb_prdata(o_apb_prdata),
        .o_apb_pready(o_apb_pready),
        .o_apb_pslverr(o_apb_pslverr),
        .i_irq_events(irq_ev),
        .o_irq(o_irq),
        .i_stats(stats),
        .o_dfifo_wr(o_dfifo_wr),
        .o_dfifo_data(o_dfifo_data),
        .i_dfifo_full(full),
        .o_ufifo_rd(o_ufifo_rd),
        .i_ufifo_data(udata),
        .i_ufifo_empty(empty),
        .o_ctrl(o_ctrl),
        .o_bit_length(o_bit_length)
    );

    task automatic do_reset;
        rst_n = 1'b0;
        psel = 0; penable = 0; paddr = '0; pwrite = 0; pwdata = '0;
        irq_ev = '0; full = 0; empty = 1; udata = '0; stats = '0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        m_ctrl = '0; m_bitlen = 16'd1000; m_en = '0; m_sts = '0;
    endtask

    // One APB transfer; full is held for the first full_n access cycles.
    task automatic apb(input logic [31:0] addr, input logic wr,
                       input logic [31:0] wd, input int full_n,
                       input logic [7:0] ev,
                       output logic [31:0] rd, output logic err,
                       output int waits, output int pushes,
                       output logic [7:0] pdata, output int pops,
                       output logic tmo);
        rd = '0; err = 0; waits = 0; pushes = 0; pdata = '0; pops = 0; tmo = 1;
        @(posedge clk); #1;
        psel = 1; penable = 0; paddr = addr; pwrite = wr; pwdata = wd;
        for (int k = 0; k < 64; k++) begin
            @(posedge clk); #1;
            penable = 1;
            full = (k < full_n);
            irq_ev = (k == 0) ? ev : 8'h0;
            @(negedge clk);
            if (o_dfifo_wr) begin pushes++; pdata = o_dfifo_data; end
            if (o_ufifo_rd) pops++;
            if (o_apb_pready) begin
                rd = o_apb_prdata; err = o_apb_pslverr; tmo = 0;
                break;
            end
            waits++;
        end
        @(posedge clk); #1;
        psel = 0; penable = 0; full = 0; irq_ev = '0;
    endtask

    task automatic test_reset;
        logic [31:0] rd; logic err, tmo; int wt, pu, po; logic [7:0] pd;
        rst_n = 1'b0;
        @(negedge clk);
        n_cmp++;
        if ({o_apb_pready, o_apb_pslverr, o_apb_prdata, o_irq, o_ctrl,
             o_dfifo_wr, o_ufifo_rd} !== '0) begin
            n_bad++; $display("FAIL reset_outs got %b/%b/%h/%b/%h exp all 0",
                o_apb_pready, o_apb_pslverr, o_apb_prdata, o_irq, o_ctrl);
        end
        n_cmp++;
        if (o_bit_length !== 16'd1000) begin
            n_bad++; $display("FAIL reset_bitlen_out got %0d exp 1000", o_bit_length);
        end
        do_reset();
        apb(32'h04, 0, 0, 0, 0, rd, err, wt, pu, pd, po, tmo);
        n_cmp++;
        if (rd !== 32'd1000) begin n_bad++; $display("FAIL reset_bitlen got %h exp %h", rd, 32'd1000); end
        n_cmp++;
        if (wt !== 1) begin n_bad++; $display("FAIL reset_latency got %0d exp 1", wt); end
        apb(32'h00, 0, 0, 0, 0, rd, err, wt, pu, pd, po, tmo);
        n_cmp++;
        if (rd !== 32'h0 || err !== 1'b0) begin n_bad++; $display("FAIL reset_ctrl got %h/%b exp 0/0", rd, err); end
    endtask

    task automatic test_txdata;
        logic [31:0] rd; logic err, tmo; int wt, pu, po; logic [7:0] pd;
        apb(32'h10, 1, 32'hA5, 0, 0, rd, err, wt, pu, pd, po, tmo);
        n_cmp++;
        if (pu !== 1 || pd !== 8'hA5) begin n_bad++; $display("FAIL tx_push got %0d/%h exp 1/a5", pu, pd); end
        n_cmp++;
        if (err !== 1'b0 || wt !== 1) begin n_bad++; $display("FAIL tx_resp got %b/%0d exp 0/1", err, wt); end
    endtask

    task automatic test_backpressure;
        logic [31:0] rd; logic err, tmo; int wt, pu, po; logic [7:0] pd;
        apb(32'h10, 1, 32'h3E, 5, 0, rd, err, wt, pu, pd, po, tmo);
        n_cmp++;
        if (wt !== 6 || pu !== 1 || pd !== 8'h3E || err !== 1'b0) begin
            n_bad++; $display("FAIL bp_wait got %0d/%0d/%h/%b exp 6/1/3e/0", wt, pu, pd, err);
        end
        apb(32'h10, 1, 32'h77, 20, 0, rd, err, wt, pu, pd, po, tmo);
        n_cmp++;
        if (wt !== W + 1 || pu !== 0 || err !== 1'b1 || rd !== 32'h0) begin
            n_bad++; $display("FAIL bp_timeout got %0d/%0d/%b/%h exp %0d/0/1/0", wt, pu, err, rd, W + 1);
        end
    endtask

    task automatic test_rxdata;
        logic [31:0] rd; logic err, tmo; int wt, pu, po; logic [7:0] pd;
        empty = 0; udata = 8'h3C;
        apb(32'h14, 0, 0, 0, 0, rd, err, wt, pu, pd, po, tmo);
        n_cmp++;
        if (rd !== 32'h8000_003C || po !== 1) begin n_bad++; $display("FAIL rx_pop got %h/%0d exp 8000003c/1", rd, po); end
        empty = 1;
        apb(32'h14, 0, 0, 0, 0, rd, err, wt, pu, pd, po, tmo);
        n_cmp++;
        if (rd !== 32'h0 || po !== 0 || err !== 1'b0) begin n_bad++; $display("FAIL rx_empty got %h/%0d/%b exp 0/0/0", rd, po, err); end
    endtask

    task automatic test_irq;
        logic [31:0] rd; logic err, tmo; int wt, pu, po; logic [7:0] pd;
        apb(32'h08, 1, 32'h4, 0, 0, rd, err, wt, pu, pd, po, tmo);
        @(posedge clk); #1 irq_ev = 8'h04;
        @(posedge clk); #1 irq_ev = 8'h00;
        repeat (2) @(negedge clk);
        n_cmp++;
        if (o_irq !== 1'b1) begin n_bad++; $display("FAIL irq_set got %b exp 1", o_irq); end
        apb(32'h0C, 1, 32'h4, 0, 8'h04, rd, err, wt, pu, pd, po, tmo);
        apb(32'h0C, 0, 0, 0, 0, rd, err, wt, pu, pd, po, tmo);
        n_cmp++;
        if (rd !== 32'h4 || o_irq !== 1'b1) begin n_bad++; $display("FAIL irq_set_wins got %h/%b exp 4/1", rd, o_irq); end
        apb(32'h0C, 1, 32'h4, 0, 0, rd, err, wt, pu, pd, po, tmo);
        @(negedge clk);
        n_cmp++;
        if (o_irq !== 1'b0) begin n_bad++; $display("FAIL irq_clear got %b exp 0", o_irq); end
        apb(32'h0C, 0, 0, 0, 0, rd, err, wt, pu, pd, po, tmo);
        n_cmp++;
        if (rd !== 32'h0) begin n_bad++; $display("FAIL irq_sts_clear got %h exp 0", rd); end
    endtask

    task automatic test_errors;
        logic [31:0] rd; logic err, tmo; int wt, pu, po; logic [7:0] pd;
        logic [31:0] addrs [4];
        logic        wrs [4];
        addrs = '{32'h18, 32'h22, 32'h40, 32'h01};
        wrs = '{1'b1, 1'b0, 1'b0, 1'b1};
        apb(32'h00, 1, 32'h5A, 0, 0, rd, err, wt, pu, pd, po, tmo);
        for (int i = 0; i < 4; i++) begin
            apb(addrs[i], wrs[i], 32'hFF, 0, 0, rd, err, wt, pu, pd, po, tmo);
            n_cmp++;
            if (err !== 1'b1 || rd !== 32'h0 || wt !== 1) begin
                n_bad++; $display("FAIL err_%h got %b/%h/%0d exp 1/0/1", addrs[i], err, rd, wt);
            end
        end
        apb(32'h00, 0, 0, 0, 0, rd, err, wt, pu, pd, po, tmo);
        n_cmp++;
        if (rd !== 32'h5A) begin n_bad++; $display("FAIL err_no_side_effect got %h exp 5a", rd); end
    endtask

    task automatic test_random;
        logic [31:0] rd, addr, wd, e_rd; logic err, tmo, wr, bad, e_err, is_tx;
        int wt, pu, po, full_n, e_wt, e_pu, e_po, sel;
        logic [7:0] pd, ev;
        do_reset();
        for (int it = 0; it < 150; it++) begin
            sel = $urandom_range(0, 11);
            if (sel < 8) addr = 32'(sel * 4);
            else if (sel == 8) addr = 32'($urandom_range(0, 7) * 4 + $urandom_range(1, 3));
            else if (sel == 9) addr = 32'h20 + 32'($urandom_range(0, 31));
            else if (sel == 10) addr = 32'h1 << $urandom_range(5, 31);
            else addr = 32'h10;
            wr = 1'($urandom_range(0, 1));
            wd = $urandom;
            ev = ($urandom_range(0, 2) == 0) ? 8'($urandom) : 8'h0;
            empty = 1'($urandom_range(0, 1));
            udata = 8'($urandom);
            stats = $urandom;
            bad = (addr[1:0] != 0) || (addr > 32'h1F) ||
                  (wr && (addr == 32'h14 || addr == 32'h18 || addr == 32'h1C));
            is_tx = !bad && wr && addr == 32'h10;
            full_n = (is_tx && $urandom_range(0, 2) == 0) ? $urandom_range(1, 20) : 0;
            e_err = bad || (is_tx && full_n > W);
            e_wt = !is_tx ? 1 : (full_n == 0 ? 1 : (full_n <= W ? full_n + 1 : W + 1));
            e_pu = (is_tx && full_n <= W) ? 1 : 0;
            e_po = (!bad && !wr && addr == 32'h14 && !empty) ? 1 : 0;
            e_rd = '0;
            if (!bad && !wr) begin
                case (addr)
                    32'h00: e_rd = {24'h0, m_ctrl};
                    32'h04: e_rd = {16'h0, m_bitlen};
                    32'h08: e_rd = {24'h0, m_en};
                    32'h0C: e_rd = {24'h0, m_sts};
                    32'h14: e_rd = empty ? 32'h0 : {1'b1, 23'h0, udata};
                    32'h18: e_rd = stats;
                    default: e_rd = '0;
                endcase
            end
            if (!bad && wr) begin
                if (addr == 32'h00) m_ctrl = wd[7:0];
                if (addr == 32'h04) m_bitlen = wd[15:0];
                if (addr == 32'h08) m_en = wd[7:0];
                if (addr == 32'h0C) m_sts = m_sts & ~wd[7:0];
            end
            m_sts = m_sts | ev;
            apb(addr, wr, wd, full_n, ev, rd, err, wt, pu, pd, po, tmo);
            @(negedge clk);
            n_cmp++;
            if (tmo !== 1'b0) begin n_bad++; $display("FAIL rnd%0d_timeout addr %h no pready", it, addr); end
            n_cmp++;
            if (rd !== e_rd || err !== e_err) begin
                n_bad++; $display("FAIL rnd%0d_resp addr %h wr %b got %h/%b exp %h/%b", it, addr, wr, rd, err, e_rd, e_err);
            end
            n_cmp++;
            if (wt !== e_wt) begin n_bad++; $display("FAIL rnd%0d_latency addr %h got %0d exp %0d", it, addr, wt, e_wt); end
            n_cmp++;
            if (pu !== e_pu || po !== e_po || (e_pu == 1 && pd !== wd[7:0])) begin
                n_bad++; $display("FAIL rnd%0d_fifo got %0d/%0d/%h exp %0d/%0d/%h", it, pu, po, pd, e_pu, e_po, wd[7:0]);
            end
            n_cmp++;
            if (o_irq !== |(m_sts & m_en) || o_ctrl !== m_ctrl || o_bit_length !== m_bitlen) begin
                n_bad++; $display("FAIL rnd%0d_state got %b/%h/%h exp %b/%h/%h", it, o_irq, o_ctrl,
                    o_bit_length, |(m_sts & m_en), m_ctrl, m_bitlen);
            end
        end
    endtask

    task automatic test_reset_wait;
        logic [31:0] rd; logic err, tmo; int wt, pu, po; logic [7:0] pd;
        int pushes, readies;
        pushes = 0; readies = 0;
        apb(32'h00, 1, 32'h33, 0, 0, rd, err, wt, pu, pd, po, tmo);
        @(posedge clk); #1;
        psel = 1; penable = 0; paddr = 32'h10; pwrite = 1; pwdata = 32'hC3; full = 1;
        @(posedge clk); #1 penable = 1;
        repeat (3) begin
            @(negedge clk);
            if (o_dfifo_wr) pushes++;
            if (o_apb_pready) readies++;
        end
        #2 rst_n = 1'b0;
        #1 psel = 0; penable = 0;
        repeat (3) begin
            @(negedge clk);
            full = 0;
            if (o_dfifo_wr) pushes++;
            if (o_apb_pready) readies++;
        end
        n_cmp++;
        if (pushes !== 0 || readies !== 0) begin n_bad++; $display("FAIL rstwait got push %0d ready %0d exp 0/0", pushes, readies); end
        @(posedge clk); #1 rst_n = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (o_ctrl !== 8'h0 || o_bit_length !== 16'd1000 || o_apb_pready !== 1'b0 || o_dfifo_wr !== 1'b0) begin
            n_bad++; $display("FAIL rstwait_after got %h/%0d/%b/%b exp 0/1000/0/0", o_ctrl, o_bit_length, o_apb_pready, o_dfifo_wr);
        end
    endtask

    initial begin
        test_reset();
        test_txdata();
        test_backpressure();
        test_rxdata();
        test_irq();
        test_errors();
        test_random();
        test_reset_wait();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
